interpolator: RTL and testbench

- Rate-increasing counterpart of the team's decimator: takes one signed sample per input period and produces TIMES samples, one per output clock-enable.
- Upsampling modes: sample-and-hold, zero-stuffing, or linear interpolation between consecutive samples.
- Sits between a low-rate producer (for example the decimator's `data_out`/`new_sample` pair) and high-rate consumers (DAC/PWM path, FFT input test feeds).
- A 2-entry input buffer decouples producer timing from output phase.

---
 rtl/interpolator.sv | 156 +++++++++++++++
 tb/tb_interpolator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/interpolator.sv
// rtl/interpolator.sv - signed sample-rate interpolator (hold / zero-stuff / linear)
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   ce         output-rate clock enable, one output sample per ce cycle
//   clear      synchronous flush: empties buffer, clears flags, returns to IDLE
//   in_valid   data_in valid this cycle
//   data_in    signed input sample
//   in_ready   input buffer not full
//   data_out   signed output sample, registered
//   out_valid  one-clk pulse when data_out is updated
//   overflow   sticky: sample offered while buffer full
//   underflow  sticky: segment started with buffer empty
module interpolator #(
  parameter int WIDTH = 8,
  parameter int TIMES = 4,
  parameter int MODE  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ce,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] data_in,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] data_out,
  output logic                    out_valid,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int LOG2 = $clog2(TIMES);
  localparam int PW   = WIDTH + 1 + LOG2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [LOG2-1:0]         phase;
  logic signed [WIDTH-1:0] prev;
  logic signed [WIDTH-1:0] cur;

  logic signed [WIDTH-1:0] fifo_mem [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;

  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    start;
  logic                    emit;
  logic signed [WIDTH-1:0] prev_n;
  logic signed [WIDTH-1:0] cur_n;
  logic signed [WIDTH:0]   diff;
  logic signed [PW-1:0]    diff_ext;
  logic signed [PW-1:0]    phase_ext;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    shifted;
  logic signed [WIDTH-1:0] out_val;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  // in_ready comes from the registered count only, so a pop in the same
  // cycle never opens a slot for a push while full.
  assign in_ready = !full;
  assign push     = in_valid && !full;

  // A segment starts at phase 0 in RUN, or on the first ce in IDLE once a
  // sample is buffered. The first output of a segment is emitted that cycle.
  assign start = ce && ((state == RUN) ? (phase == '0) : !empty);
  assign pop   = start && !empty;
  assign emit  = ce && ((state == RUN) || !empty);

  // Post-update operands; the output of the current ce uses these values.
  assign prev_n = start ? cur : prev;
  assign cur_n  = pop ? fifo_mem[rd_ptr] : cur;

  // Linear term: floor((cur - prev) * k / TIMES). The product is exact in PW
  // bits and the result lies between prev and cur, so truncating the sum
  // back to WIDTH bits cannot wrap.
  assign diff      = {cur_n[WIDTH-1], cur_n} - {prev_n[WIDTH-1], prev_n};
  assign diff_ext  = {{LOG2{diff[WIDTH]}}, diff};
  assign phase_ext = {{(WIDTH + 1){1'b0}}, phase};
  assign prod      = diff_ext * phase_ext;
  assign shifted   = prod >>> LOG2;

  always_comb begin
    out_val = prev_n;
    case (MODE)
      0:       out_val = prev_n;
      1:       out_val = (phase == '0) ? prev_n : '0;
      default: out_val = prev_n + shifted[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      phase       <= '0;
      prev        <= '0;
      cur         <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      data_out    <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      phase       <= '0;
      prev        <= '0;
      cur         <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      data_out    <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= data_in;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};

      if (in_valid && full) begin
        overflow <= 1'b1;
      end
      // Starved segment: prev takes cur and the segment stays flat.
      if (start && empty) begin
        underflow <= 1'b1;
      end

      prev      <= prev_n;
      cur       <= cur_n;
      out_valid <= emit;
      if (emit) begin
        data_out <= out_val;
        phase    <= phase + 1'b1;
        state    <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_interpolator.sv
// tb/tb_interpolator.sv - directed self-checking bench for interpolator
module tb_interpolator;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ce = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [7:0] data_in = '0;

  logic              l_ready, l_valid, l_ovf, l_unf;
  logic signed [7:0] l_data;
  logic              h_ready, h_valid, h_ovf, h_unf;
  logic signed [7:0] h_data;
  logic              z_ready, z_valid, z_ovf, z_unf;
  logic signed [7:0] z_data;

  int n_vec = 0;
  int n_err = 0;
  int lin_q[$];
  int hold_q[$];
  int zero_q[$];

  interpolator #(.WIDTH(8), .TIMES(4), .MODE(2)) u_lin (
    .clk(clk), .reset_n(reset_n), .ce(ce), .clear(clear),
    .in_valid(in_valid), .data_in(data_in), .in_ready(l_ready),
    .data_out(l_data), .out_valid(l_valid), .overflow(l_ovf), .underflow(l_unf)
  );

  interpolator #(.WIDTH(8), .TIMES(4), .MODE(0)) u_hold (
    .clk(clk), .reset_n(reset_n), .ce(ce), .clear(clear),
    .in_valid(in_valid), .data_in(data_in), .in_ready(h_ready),
    .data_out(h_data), .out_valid(h_valid), .overflow(h_ovf), .underflow(h_unf)
  );

  interpolator #(.WIDTH(8), .TIMES(4), .MODE(1)) u_zero (
    .clk(clk), .reset_n(reset_n), .ce(ce), .clear(clear),
    .in_valid(in_valid), .data_in(data_in), .in_ready(z_ready),
    .data_out(z_data), .out_valid(z_valid), .overflow(z_ovf), .underflow(z_unf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (l_valid) lin_q.push_back(int'(l_data));
    if (h_valid) hold_q.push_back(int'(h_data));
    if (z_valid) zero_q.push_back(int'(z_data));
  end

  task automatic cyc(input logic c, input logic v, input int d);
    @(negedge clk);
    ce       = c;
    in_valid = v;
    data_in  = 8'(d);
  endtask

  task automatic flush();
    cyc(1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    ce = 1'b0; in_valid = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    lin_q.delete(); hold_q.delete(); zero_q.delete();
  endtask

  task automatic test_reset();
    n_vec++; if (l_ready !== 1'b1 || h_ready !== 1'b1 || z_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b%b%b want 111", l_ready, h_ready, z_ready); end
    n_vec++; if (l_valid !== 1'b0 || l_data !== 8'sd0) begin n_err++; $display("FAIL reset_out: valid=%b data=%0d want 0/0", l_valid, l_data); end
    n_vec++; if ({l_ovf, l_unf, h_ovf, h_unf, z_ovf, z_unf} !== 6'b0) begin n_err++; $display("FAIL reset_flags: got %b want 000000", {l_ovf, l_unf, h_ovf, h_unf, z_ovf, z_unf}); end
    // Reach RUN with a full FIFO and a dropped sample.
    cyc(1'b0, 1'b1, 7);
    cyc(1'b1, 1'b1, 8);
    cyc(1'b1, 1'b1, 9);
    cyc(1'b0, 1'b1, 10);
    cyc(1'b0, 1'b0, 0);
    n_vec++; if (l_ovf !== 1'b1 || l_ready !== 1'b0) begin n_err++; $display("FAIL pre_reset_full: ovf=%b ready=%b want 1/0", l_ovf, l_ready); end
    reset_n = 1'b0;
    @(negedge clk);
    n_vec++; if (l_data !== 8'sd0 || l_valid !== 1'b0) begin n_err++; $display("FAIL midrun_reset_out: data=%0d valid=%b want 0/0", l_data, l_valid); end
    n_vec++; if (l_ready !== 1'b1 || l_ovf !== 1'b0 || l_unf !== 1'b0) begin n_err++; $display("FAIL midrun_reset_state: ready=%b ovf=%b unf=%b want 1/0/0", l_ready, l_ovf, l_unf); end
    reset_n = 1'b1;
    @(negedge clk);
    lin_q.delete(); hold_q.delete(); zero_q.delete();
    repeat (8) cyc(1'b1, 1'b0, 0);
    flush();
    n_vec++; if (lin_q.size() != 0) begin n_err++; $display("FAIL idle_no_output: got %0d outputs want 0", lin_q.size()); end
  endtask

  task automatic test_linear_ramp();
    int el[12];
    int eh[12];
    int ez[12];
    int v;
    el = '{0, 10, 20, 30, 40, 50, 60, 70, 80, 50, 20, -10};
    eh = '{0, 0, 0, 0, 40, 40, 40, 40, 80, 80, 80, 80};
    ez = '{0, 0, 0, 0, 40, 0, 0, 0, 80, 0, 0, 0};
    do_clear();
    cyc(1'b0, 1'b1, 40);
    cyc(1'b0, 1'b1, 80);
    cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, -40);
    repeat (10) cyc(1'b1, 1'b0, 0);
    flush();
    n_vec++; if (lin_q.size() != 12) begin n_err++; $display("FAIL ramp_count: got %0d want 12", lin_q.size()); end
    for (int i = 0; i < 12; i++) begin
      v = (i < lin_q.size()) ? lin_q[i] : -999;
      n_vec++; if (v !== el[i]) begin n_err++; $display("FAIL ramp_lin[%0d]: got %0d want %0d", i, v, el[i]); end
      v = (i < hold_q.size()) ? hold_q[i] : -999;
      n_vec++; if (v !== eh[i]) begin n_err++; $display("FAIL ramp_hold[%0d]: got %0d want %0d", i, v, eh[i]); end
      v = (i < zero_q.size()) ? zero_q[i] : -999;
      n_vec++; if (v !== ez[i]) begin n_err++; $display("FAIL ramp_zero[%0d]: got %0d want %0d", i, v, ez[i]); end
    end
    n_vec++; if (l_ovf !== 1'b0 || l_unf !== 1'b0) begin n_err++; $display("FAIL ramp_flags: ovf=%b unf=%b want 0/0", l_ovf, l_unf); end
  endtask

  task automatic test_floor();
    int el[4];
    int v;
    el = '{0, -1, -2, -3};
    do_clear();
    cyc(1'b0, 1'b1, -3);
    repeat (4) cyc(1'b1, 1'b0, 0);
    flush();
    n_vec++; if (lin_q.size() != 4) begin n_err++; $display("FAIL floor_count: got %0d want 4", lin_q.size()); end
    for (int i = 0; i < 4; i++) begin
      v = (i < lin_q.size()) ? lin_q[i] : -999;
      n_vec++; if (v !== el[i]) begin n_err++; $display("FAIL floor_lin[%0d]: got %0d want %0d", i, v, el[i]); end
    end
  endtask

  task automatic test_hold_zero();
    int el[8];
    int eh[8];
    int ez[8];
    int v;
    el = '{0, 1, 2, 3, 5, 6, 7, 8};
    eh = '{0, 0, 0, 0, 5, 5, 5, 5};
    ez = '{0, 0, 0, 0, 5, 0, 0, 0};
    do_clear();
    cyc(1'b0, 1'b1, 5);
    cyc(1'b0, 1'b1, 9);
    repeat (8) cyc(1'b1, 1'b0, 0);
    flush();
    n_vec++; if (hold_q.size() != 8 || zero_q.size() != 8) begin n_err++; $display("FAIL hz_count: got %0d/%0d want 8/8", hold_q.size(), zero_q.size()); end
    for (int i = 0; i < 8; i++) begin
      v = (i < hold_q.size()) ? hold_q[i] : -999;
      n_vec++; if (v !== eh[i]) begin n_err++; $display("FAIL hz_hold[%0d]: got %0d want %0d", i, v, eh[i]); end
      v = (i < zero_q.size()) ? zero_q[i] : -999;
      n_vec++; if (v !== ez[i]) begin n_err++; $display("FAIL hz_zero[%0d]: got %0d want %0d", i, v, ez[i]); end
      v = (i < lin_q.size()) ? lin_q[i] : -999;
      n_vec++; if (v !== el[i]) begin n_err++; $display("FAIL hz_lin[%0d]: got %0d want %0d", i, v, el[i]); end
    end
  endtask

  task automatic test_overflow_underflow();
    int el[12];
    int eh[12];
    int v;
    el = '{0, 2, 5, 7, 10, 12, 15, 17, 20, 20, 20, 20};
    eh = '{0, 0, 0, 0, 10, 10, 10, 10, 20, 20, 20, 20};
    do_clear();
    cyc(1'b0, 1'b1, 10);
    cyc(1'b0, 1'b1, 20);
    cyc(1'b0, 1'b1, 30);
    n_vec++; if (l_ready !== 1'b0 || l_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_after_two: ready=%b ovf=%b want 0/0", l_ready, l_ovf); end
    cyc(1'b0, 1'b0, 0);
    n_vec++; if (l_ovf !== 1'b1 || l_ready !== 1'b0) begin n_err++; $display("FAIL ovf_after_three: ovf=%b ready=%b want 1/0", l_ovf, l_ready); end
    repeat (8) cyc(1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 0);
    n_vec++; if (l_unf !== 1'b0 || l_ready !== 1'b1) begin n_err++; $display("FAIL drained: unf=%b ready=%b want 0/1", l_unf, l_ready); end
    repeat (4) cyc(1'b1, 1'b0, 0);
    flush();
    n_vec++; if (l_unf !== 1'b1 || l_ovf !== 1'b1) begin n_err++; $display("FAIL unf_set: unf=%b ovf=%b want 1/1", l_unf, l_ovf); end
    n_vec++; if (lin_q.size() != 12) begin n_err++; $display("FAIL unf_count: got %0d want 12", lin_q.size()); end
    for (int i = 0; i < 12; i++) begin
      v = (i < lin_q.size()) ? lin_q[i] : -999;
      n_vec++; if (v !== el[i]) begin n_err++; $display("FAIL unf_lin[%0d]: got %0d want %0d", i, v, el[i]); end
      v = (i < hold_q.size()) ? hold_q[i] : -999;
      n_vec++; if (v !== eh[i]) begin n_err++; $display("FAIL unf_hold[%0d]: got %0d want %0d", i, v, eh[i]); end
    end
    do_clear();
    n_vec++; if (l_ovf !== 1'b0 || l_unf !== 1'b0 || l_ready !== 1'b1) begin n_err++; $display("FAIL clear_flags: ovf=%b unf=%b ready=%b want 0/0/1", l_ovf, l_unf, l_ready); end
    repeat (4) cyc(1'b1, 1'b0, 0);
    flush();
    n_vec++; if (lin_q.size() != 0) begin n_err++; $display("FAIL clear_idle: got %0d outputs want 0", lin_q.size()); end
  endtask

  task automatic test_sparse_ce();
    int el[12];
    int v;
    el = '{0, 10, 20, 30, 40, 50, 60, 70, 80, 50, 20, -10};
    do_clear();
    cyc(1'b0, 1'b1, 40);
    // ce every 3rd clk; 80 and -40 are pushed on segment-start ce cycles.
    for (int t = 0; t < 36; t++) begin
      cyc((t % 3) == 0, (t == 0) || (t == 12), (t == 0) ? 80 : -40);
    end
    flush();
    n_vec++; if (lin_q.size() != 12) begin n_err++; $display("FAIL sparse_count: got %0d want 12", lin_q.size()); end
    for (int i = 0; i < 12; i++) begin
      v = (i < lin_q.size()) ? lin_q[i] : -999;
      n_vec++; if (v !== el[i]) begin n_err++; $display("FAIL sparse_lin[%0d]: got %0d want %0d", i, v, el[i]); end
    end
    n_vec++; if (l_ovf !== 1'b0 || l_unf !== 1'b0) begin n_err++; $display("FAIL sparse_flags: ovf=%b unf=%b want 0/0", l_ovf, l_unf); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_linear_ramp();
    test_floor();
    test_hold_zero();
    test_overflow_underflow();
    test_sparse_ce();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
